// File: rtl/weight_buffer_ctrl_if.sv
// rtl/weight_buffer_ctrl_if.sv - load stream, weight strobe and SRAM pin bundle for weight_buffer_ctrl
interface weight_buffer_ctrl_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              w_valid;
   logic              w_last;
   logic              sram_en_n;
   logic              sram_wr_n;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;

   modport master (
      input  in_valid, in_data,
      output in_ready, w_valid, w_last, sram_en_n, sram_wr_n, sram_addr, sram_wdata
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, w_valid, w_last, sram_en_n, sram_wr_n, sram_addr, sram_wdata
   );
endinterface

// File: rtl/weight_buffer_ctrl.sv
// rtl/weight_buffer_ctrl.sv - load/read sequencer owning the ternary weight SRAM control pins
module weight_buffer_ctrl #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [ADDR_W-2:0] load_words,
   input  logic              rd_start,
   input  logic [ADDR_W-1:0] rd_base,
   input  logic [ADDR_W:0]   rd_len,
   output logic              busy,
   output logic              done,
   weight_buffer_ctrl_if.master bus
);

   typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} state_t;

   state_t            state;
   logic [ADDR_W-2:0] load_left;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W:0]   rd_left;
   logic [RD_LAT-1:0] vld_pipe;
   logic [RD_LAT-1:0] last_pipe;
   logic              done_q;
   logic              hs;
   logic              rd_issue;
   logic              unused_base_lsbs;

   assign unused_base_lsbs = ^load_base[1:0];

   assign bus.in_ready = (state == LOAD) && (load_left != '0);
   assign hs           = bus.in_valid && bus.in_ready;
   // sram_en_n is held low for the whole READ state, so every READ cycle issues an address
   assign rd_issue     = (state == READ);
   assign bus.w_valid  = vld_pipe[RD_LAT-1];
   assign bus.w_last   = last_pipe[RD_LAT-1];
   assign busy         = (state != IDLE);
   assign done         = done_q | bus.w_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         load_left      <= '0;
         wr_ptr         <= '0;
         rd_left        <= '0;
         vld_pipe       <= '0;
         last_pipe      <= '0;
         done_q         <= 1'b0;
         bus.sram_en_n  <= 1'b1;
         bus.sram_wr_n  <= 1'b1;
         bus.sram_addr  <= '0;
         bus.sram_wdata <= '0;
      end else begin
         done_q <= 1'b0;

         // read-strobe delay line lines w_valid/w_last up with SRAM output data
         vld_pipe[0]  <= rd_issue;
         last_pipe[0] <= rd_issue && (rd_left == '0);
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            last_pipe[i] <= last_pipe[i-1];
         end

         case (state)
            IDLE: begin
               bus.sram_en_n <= 1'b1;
               bus.sram_wr_n <= 1'b1;
               if (load_start) begin
                  state     <= LOAD;
                  wr_ptr    <= {load_base[ADDR_W-1:2], 2'b00};
                  load_left <= load_words;
                  done_q    <= (load_words == '0);
               end else if (rd_start) begin
                  if (rd_len == '0) begin
                     state  <= DRAIN;
                     done_q <= 1'b1;
                  end else begin
                     state         <= READ;
                     bus.sram_en_n <= 1'b0;
                     bus.sram_wr_n <= 1'b1;
                     bus.sram_addr <= rd_base;
                     rd_left       <= rd_len - (ADDR_W+1)'(1);
                  end
               end
            end

            LOAD: begin
               if (hs) begin
                  bus.sram_en_n  <= 1'b0;
                  bus.sram_wr_n  <= 1'b0;
                  bus.sram_addr  <= wr_ptr;
                  bus.sram_wdata <= bus.in_data;
                  wr_ptr         <= wr_ptr + ADDR_W'(4);
                  load_left      <= load_left - (ADDR_W-1)'(1);
                  done_q         <= (load_left == (ADDR_W-1)'(1));
               end else begin
                  bus.sram_en_n <= 1'b1;
                  bus.sram_wr_n <= 1'b1;
               end
               // the cycle with no bytes left is the one presenting the final strobe and done
               if (load_left == '0) begin
                  state <= IDLE;
               end
            end

            READ: begin
               if (rd_left == '0) begin
                  bus.sram_en_n <= 1'b1;
                  state         <= DRAIN;
               end else begin
                  bus.sram_addr <= bus.sram_addr + ADDR_W'(1);
                  rd_left       <= rd_left - (ADDR_W+1)'(1);
               end
            end

            DRAIN: begin
               bus.sram_en_n <= 1'b1;
               bus.sram_wr_n <= 1'b1;
               if (done) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// tb/tb_weight_buffer_ctrl.sv - directed self-checking bench for weight_buffer_ctrl
module tb_weight_buffer_ctrl;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam int RD_LAT = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_start = 1'b0;
   logic [6:0]  load_base = '0;
   logic [5:0]  load_words = '0;
   logic        rd_start = 1'b0;
   logic [6:0]  rd_base = '0;
   logic [7:0]  rd_len = '0;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail = 0;

   logic [7:0] exp_b [0:31];
   logic [7:0] src [0:31];
   logic [7:0] mem [0:31];
   logic [1:0] sram_q;

   always #5 clk = ~clk;

   weight_buffer_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   weight_buffer_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .load_base  (load_base),
      .load_words (load_words),
      .rd_start   (rd_start),
      .rd_base    (rd_base),
      .rd_len     (rd_len),
      .busy       (busy),
      .done       (done),
      .bus        (bus)
   );

   // SRAM model: byte-wide writes, 2-bit reads with one cycle latency
   always @(posedge clk) begin
      if (!bus.sram_en_n) begin
         if (!bus.sram_wr_n) mem[bus.sram_addr[6:2]] <= bus.sram_wdata;
         else sram_q <= 2'(mem[bus.sram_addr[6:2]] >> (2 * bus.sram_addr[1:0]));
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] tern_byte();
      logic [7:0] b;
      for (int i = 0; i < 4; i++) b[2*i +: 2] = 2'($urandom_range(0, 2));
      return b;
   endfunction

   function automatic logic [1:0] val(input logic [6:0] a);
      logic [7:0] b;
      b = exp_b[a[6:2]];
      return b[2*a[1:0] +: 2];
   endfunction

   task automatic run_load(input string name, input logic [6:0] base, input int n,
                           input int gap_at, input int gap_len, input bit with_rd);
      logic [6:0] ptr;
      logic [6:0] a;
      int acc, ws, dones, bad_strobe, bad_ready, rd_seen, gap_left;
      bit prev_hs, hs, fin, strobe;
      for (int i = 0; i < n; i++) src[i] = tern_byte();
      load_base = base; load_words = 6'(n); load_start = 1'b1;
      rd_start = with_rd; rd_base = 7'd40; rd_len = 8'd3;
      step();
      load_start = 1'b0; rd_start = 1'b0;
      ptr = {base[6:2], 2'b00};
      acc = 0; ws = 0; dones = 0; bad_strobe = 0; bad_ready = 0; rd_seen = 0;
      gap_left = gap_len; prev_hs = 1'b0; fin = 1'b0;
      for (int cyc = 1; cyc <= n + gap_len + 10 && !fin; cyc++) begin
         strobe = !bus.sram_en_n && !bus.sram_wr_n;
         if (strobe) begin
            a = 7'(ptr + 4 * ws);
            chk($sformatf("%s_addr[%0d]", name, ws), bus.sram_addr, a);
            chk($sformatf("%s_data[%0d]", name, ws), bus.sram_wdata, src[ws]);
            exp_b[a[6:2]] = src[ws];
            if (!prev_hs) bad_strobe++;
            ws++;
         end else if (prev_hs) bad_strobe++;
         if (!bus.sram_en_n && bus.sram_wr_n) rd_seen++;
         if (done) begin
            dones++;
            chk({name, "_done_on_last"}, {31'd0, strobe && ws == n}, 1);
            fin = 1'b1;
         end
         if (acc < n && bus.in_ready !== 1'b1) bad_ready++;
         if (acc == n && bus.in_ready !== 1'b0) bad_ready++;
         bus.in_valid = (acc < n) && !(acc == gap_at && gap_left > 0);
         if (acc == gap_at && gap_left > 0) gap_left--;
         bus.in_data = src[acc < n ? acc : 0];
         hs = bus.in_valid && bus.in_ready;
         if (hs) acc++;
         prev_hs = hs;
         step();
      end
      bus.in_valid = 1'b0;
      chk({name, "_finished"}, {31'd0, fin}, 1);
      chk({name, "_strobes"}, ws, n);
      chk({name, "_dones"}, dones, 1);
      chk({name, "_strobe_align"}, bad_strobe, 0);
      chk({name, "_in_ready"}, bad_ready, 0);
      chk({name, "_no_read"}, rd_seen, 0);
      chk({name, "_idle_after"}, {30'd0, busy, bus.sram_en_n}, 32'h1);
   endtask

   task automatic run_read(input string name, input logic [6:0] base, input int len,
                           input bit chk_data, input bit poke);
      int na, nv, dones, bad;
      bit fin;
      rd_base = base; rd_len = 8'(len); rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      na = 0; nv = 0; dones = 0; bad = 0; fin = 1'b0;
      for (int cyc = 1; cyc <= len + RD_LAT + 8 && !fin; cyc++) begin
         if (!bus.sram_en_n) begin
            if (bus.sram_wr_n !== 1'b1 || cyc != na + 1) bad++;
            chk($sformatf("%s_addr[%0d]", name, na), bus.sram_addr, 7'(base + na));
            na++;
         end
         if (bus.w_valid) begin
            if (cyc != nv + 1 + RD_LAT) bad++;
            if (chk_data) chk($sformatf("%s_data[%0d]", name, nv), sram_q, val(7'(base + nv)));
            nv++;
         end
         if (bus.w_last !== (bus.w_valid && nv == len)) bad++;
         if (done) begin
            dones++;
            if (len > 0 && !bus.w_last) bad++;
            chk({name, "_done_cycle"}, cyc, (len == 0) ? 1 : len + RD_LAT);
            fin = 1'b1;
         end
         if (poke && cyc == 2) begin
            rd_start = 1'b1; load_start = 1'b1; rd_base = 7'd0; load_words = 6'd4;
         end else begin
            rd_start = 1'b0; load_start = 1'b0;
         end
         step();
      end
      rd_start = 1'b0; load_start = 1'b0;
      chk({name, "_finished"}, {31'd0, fin}, 1);
      chk({name, "_addrs"}, na, len);
      chk({name, "_valids"}, nv, len);
      chk({name, "_dones"}, dones, 1);
      chk({name, "_timing"}, bad, 0);
      chk({name, "_idle_after"}, {30'd0, busy, bus.sram_en_n}, 32'h1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      for (int i = 0; i < 32; i++) begin
         exp_b[i] = '0;
         mem[i] = '0;
      end

      step();
      step();
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_w_valid", bus.w_valid, 0);
      chk("rst_w_last", bus.w_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_en_n", bus.sram_en_n, 1);
      chk("rst_wr_n", bus.sram_wr_n, 1);
      chk("rst_addr", bus.sram_addr, 0);
      chk("rst_wdata", bus.sram_wdata, 0);
      reset = 1'b0;
      step();

      run_load("load_full", 7'd0, 32, -1, 0, 1'b0);
      run_read("read_full", 7'd0, 128, 1'b1, 1'b0);
      run_read("read_wrap", 7'd126, 4, 1'b1, 1'b0);
      run_load("load_wrap", 7'd125, 2, -1, 0, 1'b0);
      run_load("arb_load", 7'd8, 3, -1, 0, 1'b1);
      run_read("read_zero", 7'd5, 0, 1'b0, 1'b0);
      run_read("read_busy_start", 7'd20, 4, 1'b1, 1'b1);
      run_load("load_gap", 7'd16, 8, 3, 5, 1'b0);
      run_read("read_final", 7'd0, 128, 1'b1, 1'b0);

      rd_base = 7'd0; rd_len = 8'd10; rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      for (int i = 0; i < 5 && !bus.w_valid; i++) step();
      chk("pre_reset_w_valid", bus.w_valid, 1);
      reset = 1'b1;
      step();
      chk("mid_reset_w_valid", bus.w_valid, 0);
      chk("mid_reset_busy", busy, 0);
      chk("mid_reset_en_n", bus.sram_en_n, 1);
      reset = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
